// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Control sequencer sitting directly in front of `datapath`. One layer
//   command is accepted in IDLE. The block then walks four phases:
//     WLOAD  : N*N weight reads, weight location k = 0..N*N-1
//     CONV   : conv_len feature-map reads with the address controller on
//     DRAIN  : DRAIN_CYCLES cycles with RAM reads off so in-flight results land
//     POST   : optional post_len reads through the pool/ReLU mux, then DRAIN again
//   It finishes with a single DONE cycle that pulses `done`.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, abort          command strobe (IDLE only) / synchronous abort
//   cfg_*                 layer command, sampled only in the cycle `start` is taken
//   ready, busy, done     handshake / status
//   ctrl_*                registered control bus into `datapath`
//
// Every output is a flop. Each cycle, the next state and counter are worked
// out first. The outputs for that next state are then decoded and registered
// with it, so the outputs always describe the state the FSM is currently in.
// This keeps combinational logic off the `datapath` control inputs.
//
// Sizing assumption: the shared phase counter is ADDR_WIDTH bits wide, so
// N*N and DRAIN_CYCLES must fit in ADDR_WIDTH bits, and DRAIN_CYCLES >= 1.

module layer_sequencer #(
  parameter  int ADDR_WIDTH   = 11,
  parameter  int N            = 5,
  parameter  int DRAIN_CYCLES = 8,
  localparam int NN           = N * N,
  localparam int LOC_W        = (NN > 1) ? $clog2(NN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2:0]            cfg_mode,
  input  logic [ADDR_WIDTH-1:0] cfg_weight_base,
  input  logic [ADDR_WIDTH-1:0] cfg_ifmap_base,
  input  logic [ADDR_WIDTH-1:0] cfg_conv_len,
  input  logic [1:0]            cfg_post_sel,
  input  logic [ADDR_WIDTH-1:0] cfg_post_base,
  input  logic [ADDR_WIDTH-1:0] cfg_post_len,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  ctrl_ram_en,
  output logic                  ctrl_addr_ctrl_en,
  output logic                  ctrl_WorI,
  output logic [2:0]            ctrl_mode,
  output logic [ADDR_WIDTH-1:0] ctrl_read_addr,
  output logic [LOC_W-1:0]      ctrl_weight_location,
  output logic [1:0]            ctrl_mux_sel
);

  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] WLOAD_END = ADDR_WIDTH'(NN - 1);
  localparam logic [ADDR_WIDTH-1:0] DRAIN_END = ADDR_WIDTH'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_CONV,
    S_DRAIN,
    S_POST,
    S_DONE
  } state_t;

  // Latched layer command. Only the copy taken in the start cycle is used.
  typedef struct packed {
    logic [2:0]            mode;
    logic [ADDR_WIDTH-1:0] weight_base;
    logic [ADDR_WIDTH-1:0] ifmap_base;
    logic [ADDR_WIDTH-1:0] conv_len;
    logic [1:0]            post_sel;
    logic [ADDR_WIDTH-1:0] post_base;
    logic [ADDR_WIDTH-1:0] post_len;
  } cmd_t;

  state_t                state, nxt_state;
  logic [ADDR_WIDTH-1:0] cnt, nxt_cnt;
  logic                  post_phase, nxt_post_phase;
  cmd_t                  cmd, nxt_cmd;

  // Decoded values for the next cycle; these land in the output flops.
  logic                  n_ready, n_busy, n_done;
  logic                  n_ram_en, n_addr_ctrl_en, n_wori;
  logic [2:0]            n_mode;
  logic [ADDR_WIDTH-1:0] n_read_addr;
  logic [LOC_W-1:0]      n_loc;
  logic [1:0]            n_mux_sel;

  // --------------------------------------------------------------------------
  // Next state / counter
  // --------------------------------------------------------------------------
  // A single counter is shared by all phases. It is reset to 0 on every phase
  // change, so each phase starts counting at index 0 with no bubble cycle.
  always_comb begin
    nxt_state      = state;
    nxt_cnt        = cnt + ONE;
    nxt_post_phase = post_phase;
    nxt_cmd        = cmd;

    case (state)
      S_IDLE: begin
        nxt_cnt = '0;
        if (start) begin
          nxt_state            = S_WLOAD;
          nxt_post_phase       = 1'b0;
          nxt_cmd.mode         = cfg_mode;
          nxt_cmd.weight_base  = cfg_weight_base;
          nxt_cmd.ifmap_base   = cfg_ifmap_base;
          nxt_cmd.conv_len     = cfg_conv_len;
          nxt_cmd.post_sel     = cfg_post_sel;
          nxt_cmd.post_base    = cfg_post_base;
          nxt_cmd.post_len     = cfg_post_len;
        end
      end

      S_WLOAD: begin
        if (cnt == WLOAD_END) begin
          nxt_cnt        = '0;
          nxt_post_phase = 1'b0;
          // A zero-length convolution goes straight to the drain.
          nxt_state      = (cmd.conv_len == '0) ? S_DRAIN : S_CONV;
        end
      end

      S_CONV: begin
        if (cnt == cmd.conv_len - ONE) begin
          nxt_cnt        = '0;
          nxt_post_phase = 1'b0;
          nxt_state      = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (cnt == DRAIN_END) begin
          nxt_cnt = '0;
          // post_phase records which drain this is: 0 = after CONV,
          // 1 = after POST.
          if (!post_phase && (cmd.post_len != '0))
            nxt_state = S_POST;
          else
            nxt_state = S_DONE;
        end
      end

      S_POST: begin
        if (cnt == cmd.post_len - ONE) begin
          nxt_cnt        = '0;
          nxt_post_phase = 1'b1;
          nxt_state      = S_DRAIN;
        end
      end

      S_DONE: begin
        nxt_cnt   = '0;
        nxt_state = S_IDLE;
      end

      default: begin
        nxt_cnt   = '0;
        nxt_state = S_IDLE;
      end
    endcase

    // Abort overrides every transition, including a start taken in IDLE.
    if (abort) begin
      nxt_state      = S_IDLE;
      nxt_cnt        = '0;
      nxt_post_phase = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode for the state being entered
  // --------------------------------------------------------------------------
  // nxt_cmd is used instead of cmd so the first WLOAD cycle already carries
  // the command taken on the same edge.
  always_comb begin
    n_ready        = 1'b0;
    n_busy         = 1'b1;
    n_done         = 1'b0;
    n_ram_en       = 1'b0;
    n_addr_ctrl_en = 1'b0;
    n_wori         = 1'b0;
    n_mode         = '0;
    n_read_addr    = '0;
    n_loc          = '0;
    n_mux_sel      = '0;

    case (nxt_state)
      S_IDLE: begin
        n_ready = 1'b1;
        n_busy  = 1'b0;
      end

      S_WLOAD: begin
        n_wori      = 1'b1;
        n_ram_en    = 1'b1;
        n_mode      = nxt_cmd.mode;
        n_read_addr = nxt_cmd.weight_base + nxt_cnt;
        n_loc       = nxt_cnt[LOC_W-1:0];
      end

      S_CONV: begin
        n_ram_en       = 1'b1;
        n_addr_ctrl_en = 1'b1;
        n_mode         = nxt_cmd.mode;
        n_read_addr    = nxt_cmd.ifmap_base + nxt_cnt;
      end

      S_DRAIN: begin
        // RAM reads stop. The write-back side keeps running, and the address
        // and mux select keep the values from the last read.
        n_addr_ctrl_en = 1'b1;
        n_mode         = nxt_cmd.mode;
        n_read_addr    = ctrl_read_addr;
        n_mux_sel      = ctrl_mux_sel;
      end

      S_POST: begin
        n_ram_en       = 1'b1;
        n_addr_ctrl_en = 1'b1;
        n_mode         = nxt_cmd.mode;
        n_mux_sel      = nxt_cmd.post_sel;
        n_read_addr    = nxt_cmd.post_base + nxt_cnt;
      end

      S_DONE: begin
        n_done = 1'b1;
      end

      default: begin
        n_ready = 1'b1;
        n_busy  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      cnt                  <= '0;
      post_phase           <= 1'b0;
      cmd                  <= '0;
      ready                <= 1'b1;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      ctrl_ram_en          <= 1'b0;
      ctrl_addr_ctrl_en    <= 1'b0;
      ctrl_WorI            <= 1'b0;
      ctrl_mode            <= '0;
      ctrl_read_addr       <= '0;
      ctrl_weight_location <= '0;
      ctrl_mux_sel         <= '0;
    end else begin
      state                <= nxt_state;
      cnt                  <= nxt_cnt;
      post_phase           <= nxt_post_phase;
      cmd                  <= nxt_cmd;
      ready                <= n_ready;
      busy                 <= n_busy;
      done                 <= n_done;
      ctrl_ram_en          <= n_ram_en;
      ctrl_addr_ctrl_en    <= n_addr_ctrl_en;
      ctrl_WorI            <= n_wori;
      ctrl_mode            <= n_mode;
      ctrl_read_addr       <= n_read_addr;
      ctrl_weight_location <= n_loc;
      ctrl_mux_sel         <= n_mux_sel;
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer
//   Directed bench for layer_sequencer. For each command it builds the list
//   of expected cycles from the command fields. It then compares the packed
//   output bus against that list on every negedge. The number of busy cycles
//   is compared against a hand-computed total.

module tb_layer_sequencer;

  localparam int AW = 11;
  localparam int N  = 5;
  localparam int DR = 8;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [2:0]    cfg_mode;
  logic [AW-1:0] cfg_weight_base, cfg_ifmap_base, cfg_conv_len;
  logic [1:0]    cfg_post_sel;
  logic [AW-1:0] cfg_post_base, cfg_post_len;
  logic          ready, busy, done;
  logic          ctrl_ram_en, ctrl_addr_ctrl_en, ctrl_WorI;
  logic [2:0]    ctrl_mode;
  logic [AW-1:0] ctrl_read_addr;
  logic [LW-1:0] ctrl_weight_location;
  logic [1:0]    ctrl_mux_sel;

  layer_sequencer #(.ADDR_WIDTH(AW), .N(N), .DRAIN_CYCLES(DR)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .abort               (abort),
    .cfg_mode            (cfg_mode),
    .cfg_weight_base     (cfg_weight_base),
    .cfg_ifmap_base      (cfg_ifmap_base),
    .cfg_conv_len        (cfg_conv_len),
    .cfg_post_sel        (cfg_post_sel),
    .cfg_post_base       (cfg_post_base),
    .cfg_post_len        (cfg_post_len),
    .ready               (ready),
    .busy                (busy),
    .done                (done),
    .ctrl_ram_en         (ctrl_ram_en),
    .ctrl_addr_ctrl_en   (ctrl_addr_ctrl_en),
    .ctrl_WorI           (ctrl_WorI),
    .ctrl_mode           (ctrl_mode),
    .ctrl_read_addr      (ctrl_read_addr),
    .ctrl_weight_location(ctrl_weight_location),
    .ctrl_mux_sel        (ctrl_mux_sel)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output bus layout: rdy[26] bsy[25] dn[24] ram[23] ace[22] wori[21]
  // mode[20:18] mux[17:16] addr[15:5] loc[4:0]
  function automatic logic [31:0] pk(input logic rdy, input logic bsy, input logic dn,
                                     input logic ram, input logic ace, input logic wori,
                                     input logic [2:0] md, input logic [1:0] mx,
                                     input logic [AW-1:0] ad, input logic [LW-1:0] lc);
    return {5'b0, rdy, bsy, dn, ram, ace, wori, md, mx, ad, lc};
  endfunction

  function automatic logic [31:0] obs();
    return pk(ready, busy, done, ctrl_ram_en, ctrl_addr_ctrl_en, ctrl_WorI,
              ctrl_mode, ctrl_mux_sel, ctrl_read_addr, ctrl_weight_location);
  endfunction

  localparam logic [31:0] M_LOC  = 32'h0000_001F;
  localparam logic [31:0] M_MUX  = 32'h0003_0000;
  localparam logic [31:0] M_MODE = 32'h001C_0000;
  localparam logic [31:0] M_WORI = 32'h0020_0000;

  logic [31:0] idle_v;

  typedef struct {
    logic [31:0] v;
    logic [31:0] m;
    string       tag;
  } exp_t;

  exp_t q[$];

  function automatic void push(input logic [31:0] v, input logic [31:0] m, input string tag);
    exp_t e;
    e.v = v; e.m = m; e.tag = tag;
    q.push_back(e);
  endfunction

  // The task is entered and left on a negedge. start is driven on the
  // entry negedge, so back-to-back commands also test that a start is
  // accepted in the first ready cycle. abort_at / rst_at / start_at index
  // the expected-cycle list; -1 disables each one.
  task automatic run(input string nm, input logic [2:0] md,
                     input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                     input logic [AW-1:0] clen, input logic [1:0] psel,
                     input logic [AW-1:0] pb, input logic [AW-1:0] plen,
                     input int exp_busy, input int abort_at, input int rst_at,
                     input int start_at);
    logic [AW-1:0] la;
    logic [1:0]    lm;
    logic [31:0]   dm;
    int            nb;
    q.delete();
    for (int k = 0; k < N*N; k++)
      push(pk(0,1,0,1,0,1,3'd0,2'd0, wb + AW'(k), LW'(k)), ~(M_MODE | M_MUX), "wload");
    la = wb + AW'(N*N - 1);
    dm = M_MUX;
    lm = 2'd0;
    for (int j = 0; j < int'(clen); j++)
      push(pk(0,1,0,1,1,0,md,2'd0, ib + AW'(j), LW'(0)), ~M_LOC, "conv");
    if (clen != '0) begin
      la = ib + clen - AW'(1);
      dm = '0;
    end
    for (int d = 0; d < DR; d++)
      push(pk(0,1,0,0,1,0,3'd0,lm, la, LW'(0)), ~(M_WORI | M_LOC | M_MODE | dm), "drain");
    if (plen != '0) begin
      for (int p = 0; p < int'(plen); p++)
        push(pk(0,1,0,1,1,0,3'd0,psel, pb + AW'(p), LW'(0)), ~(M_WORI | M_LOC | M_MODE), "post");
      la = pb + plen - AW'(1);
      for (int d = 0; d < DR; d++)
        push(pk(0,1,0,0,1,0,3'd0,psel, la, LW'(0)), ~(M_WORI | M_LOC | M_MODE), "drain2");
    end
    push(pk(0,1,1,0,0,0,3'd0,2'd0,'0,'0), 32'hFFFF_FFFF, "done");

    cfg_mode = md; cfg_weight_base = wb; cfg_ifmap_base = ib; cfg_conv_len = clen;
    cfg_post_sel = psel; cfg_post_base = pb; cfg_post_len = plen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    for (int i = 0; i < q.size(); i++) begin
      chk($sformatf("%s[%0d] %s", nm, i, q[i].tag), obs() & q[i].m, q[i].v & q[i].m);
      if (busy) nb++;
      if (i == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk({nm, " after abort"}, obs(), idle_v);
        return;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({nm, " after rst"}, obs(), idle_v);
        return;
      end
      if (i == start_at) begin
        // A start while busy must be ignored. The cfg inputs are also
        // scrambled to check they are no longer sampled.
        start = 1'b1;
        cfg_mode = 3'd7; cfg_weight_base = 11'h555; cfg_ifmap_base = 11'h2AA;
        cfg_conv_len = 11'd9; cfg_post_sel = 2'd3; cfg_post_base = 11'h123; cfg_post_len = 11'd6;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk({nm, " idle after done"}, obs(), idle_v);
    chk({nm, " busy cycles"}, 32'(nb), 32'(exp_busy));
  endtask

  initial begin
    idle_v = pk(1,0,0,0,0,0,3'd0,2'd0,'0,'0);
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_mode = '0; cfg_weight_base = '0; cfg_ifmap_base = '0; cfg_conv_len = '0;
    cfg_post_sel = '0; cfg_post_base = '0; cfg_post_len = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset values", obs(), idle_v);
    rst = 1'b0;
    @(negedge clk);

    // name           md    wb      ib      clen   psel  pb      plen  busy  abt  rst  st
    run("basic",     3'd1, 11'h000, 11'h040, 11'd4, 2'd0, 11'h000, 11'd0, 38,  -1,  -1,  -1);
    run("post",      3'd1, 11'h000, 11'h040, 11'd4, 2'd1, 11'h200, 11'd3, 49,  -1,  -1,  -1);
    run("skips",     3'd3, 11'h100, 11'h040, 11'd0, 2'd0, 11'h000, 11'd0, 34,  -1,  -1,  -1);
    run("wrap",      3'd5, 11'h7F0, 11'h7FE, 11'd4, 2'd0, 11'h000, 11'd0, 38,  -1,  -1,  -1);
    run("abort",     3'd1, 11'h000, 11'h040, 11'd4, 2'd0, 11'h000, 11'd0, 0,   27,  -1,  -1);
    run("restart",   3'd2, 11'h010, 11'h080, 11'd4, 2'd0, 11'h000, 11'd0, 38,  -1,  -1,  -1);
    run("ign_start", 3'd2, 11'h020, 11'h300, 11'd4, 2'd2, 11'h7FF, 11'd2, 48,  -1,  -1,   5);
    run("rst_post",  3'd1, 11'h000, 11'h040, 11'd4, 2'd1, 11'h200, 11'd3, 0,   -1,  38,  -1);
    run("after_rst", 3'd4, 11'h000, 11'h040, 11'd1, 2'd2, 11'h400, 11'd1, 44,  -1,  -1,  -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
